// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer-side front end for the core's word-addressed instruction memory.
// A host byte source (UART / debug bridge) streams little-endian bytes over a
// valid/ready handshake; every four bytes are assembled into one 32-bit word
// and written at consecutive 4-byte-aligned byte addresses starting at
// BASE_ADDR. busy holds the core off while a load is in flight.
//
// Ports
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   start, len_words      : load request (sampled in IDLE) and its length
//   abort                 : cancel a load in progress
//   byte_valid, byte_data : incoming byte stream
//   byte_ready            : a byte is accepted this cycle when valid && ready
//   mem_we, mem_addr,
//   mem_wdata             : instruction-memory write port, one strobe per word
//   busy                  : high while receiving or writing
//   done                  : one-cycle pulse after the last word is written
//   error                 : sticky, set by a start with len_words > MEM_SIZE
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_SIZE   = 64,
  parameter int                    LEN_WIDTH  = 7,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_words,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [1:0]             byte_cnt;
  logic [23:0]            byte_buf;   // bytes 0..2 of the word being assembled
  logic [LEN_WIDTH-1:0]   word_idx;
  logic [LEN_WIDTH-1:0]   len_q;

  logic byte_fire;
  logic last_byte;
  logic last_word;
  logic start_empty;
  logic start_err;
  logic start_ok;

  // abort wins over the handshake, so ready is withdrawn in an abort cycle and
  // the byte on the bus stays with the source.
  assign byte_ready  = (state == RECV) && !abort;
  assign byte_fire   = byte_ready && byte_valid;
  assign last_byte   = byte_fire && (byte_cnt == 2'd3);
  assign last_word   = (word_idx + LEN_WIDTH'(1)) == len_q;

  assign start_empty = (state == IDLE) && start && (len_words == '0);
  assign start_err   = (state == IDLE) && start && (len_words > LEN_WIDTH'(MEM_SIZE));
  assign start_ok    = (state == IDLE) && start && !start_empty && !start_err;

  assign mem_we      = (state == WRITE);
  assign busy        = (state == RECV) || (state == WRITE);
  assign done        = (state == DONE);

  // NOTE: state_next gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_empty)   state_next = DONE;
        else if (start_ok) state_next = RECV;
      end
      RECV: begin
        if (abort)          state_next = IDLE;
        else if (last_byte) state_next = WRITE;
      end
      WRITE: begin
        // The write strobe is already out this cycle; abort only stops the
        // load from continuing.
        if (abort)          state_next = IDLE;
        else if (last_word) state_next = DONE;
        else                state_next = RECV;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      byte_buf  <= '0;
      word_idx  <= '0;
      len_q     <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      error     <= 1'b0;
    end else begin
      if (start_err) error <= 1'b1;

      if (start_ok) begin
        error    <= 1'b0;
        len_q    <= len_words;
        word_idx <= '0;
        byte_cnt <= '0;   // drops any partial word left by an abort
      end

      if (byte_fire) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: byte_buf[7:0]   <= byte_data;
          2'd1: byte_buf[15:8]  <= byte_data;
          2'd2: byte_buf[23:16] <= byte_data;
          default: begin
            // Write port is only updated on the edge that enters WRITE, so
            // mem_addr/mem_wdata stay put between strobes.
            mem_wdata <= DATA_WIDTH'({byte_data, byte_buf});
            mem_addr  <= BASE_ADDR + ADDR_WIDTH'({word_idx, 2'b00});
          end
        endcase
      end

      if (state == WRITE) word_idx <= word_idx + LEN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives byte-stream loads into imem_loader and compares the observed memory
// writes and status pulses against a word-level model: word i of a load of N
// words lands at BASE + 4*i and is stream bytes 4i..4i+3, LSB first.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  len_words;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(64), .LEN_WIDTH(7), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [63:0] wq[$];          // observed writes {addr, data}
  int          done_cnt  = 0;
  int          stab_err  = 0;
  int          ready_drop = 0;
  logic        prev_ok   = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_data;

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (done) done_cnt <= done_cnt + 1;
    if (prev_ok && !prev_we && !mem_we && (mem_addr !== prev_addr || mem_wdata !== prev_data))
      stab_err <= stab_err + 1;
    prev_ok   <= !rst;
    prev_we   <= mem_we;
    prev_addr <= mem_addr;
    prev_data <= mem_wdata;
  end

  // ---------------- stimulus ----------------
  logic [7:0] stream [0:255];

  typedef struct {
    int len;
    int mode;         // 0 back-to-back, 1 valid every other cycle, 2 random
    int abort_after;  // abort when this many bytes accepted, -1 for none
    bit fixed;        // keep current stream contents
    bit poke;         // pulse start mid-load
    int exp_words;
    int exp_done;
  } vec_t;

  task automatic run_load(input vec_t v, input string tag);
    int idx, done0;
    bit fin;
    logic [31:0] w;
    if (!v.fixed) for (int i = 0; i < 4 * v.len; i++) stream[i] = 8'($urandom);
    wq.delete();
    done0 = done_cnt;
    start = 1'b1; len_words = 7'(v.len);
    @(posedge clk); #1 start = 1'b0;
    idx = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (v.abort_after >= 0 && idx == v.abort_after) begin
        abort = 1'b1; byte_valid = 1'b1; byte_data = stream[idx];
        @(posedge clk); #1 abort = 1'b0; byte_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_abort_busy"}, busy, 0);
        fin = 1'b1;
      end else begin
        byte_valid = (idx < 4 * v.len) &&
                     (v.mode == 0 || (v.mode == 1 && cyc % 2 == 0) ||
                      (v.mode == 2 && $urandom_range(1, 0) == 1));
        byte_data  = byte_valid ? stream[idx] : 8'($urandom);
        if (v.poke && cyc == 3) begin start = 1'b1; len_words = 7'd5; end
        @(negedge clk);
        if (busy && !mem_we && !byte_ready) ready_drop++;
        if (byte_valid && byte_ready) idx++;
        @(posedge clk); #1 start = 1'b0;
        if (done_cnt != done0) fin = 1'b1;
      end
    end
    byte_valid = 1'b0;
    check({tag, "_finished"}, fin, 1);
    check({tag, "_done_pulses"}, done_cnt - done0, v.exp_done);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_write_count"}, wq.size(), v.exp_words);
    for (int i = 0; i < v.exp_words && i < wq.size(); i++) begin
      w = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
      check({tag, "_write"}, wq[i], {BASE + 32'(4 * i), w});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_mem_we"},     mem_we, 0);
    check({tag, "_mem_addr"},   mem_addr, BASE);
    check({tag, "_mem_wdata"},  mem_wdata, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_error"},      error, 0);
  endtask

  vec_t vecs [0:7];

  initial begin
    vec_t rv;
    int   d0, seen, rdy_seen;
    rst = 1'b1; start = 1'b0; len_words = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0;

    vecs[0] = '{2,  0, -1, 1'b1, 1'b0, 2,  1};  // reference bytes, back-to-back
    vecs[1] = '{2,  1, -1, 1'b1, 1'b0, 2,  1};  // same bytes, gappy valid
    vecs[2] = '{3,  0,  6, 1'b0, 1'b0, 1,  0};  // abort after 2 bytes of word 1
    vecs[3] = '{2,  0, -1, 1'b0, 1'b0, 2,  1};  // restarts at BASE
    vecs[4] = '{4,  2,  8, 1'b0, 1'b0, 2,  0};  // abort during WRITE of word 1
    vecs[5] = '{2,  2, -1, 1'b0, 1'b1, 2,  1};  // start while busy ignored
    vecs[6] = '{64, 0, -1, 1'b0, 1'b0, 64, 1};  // full memory
    vecs[7] = '{1,  2,  0, 1'b0, 1'b0, 0,  0};  // abort before any byte

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven loads
    stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h00; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h05; stream[6] = 8'h10; stream[7] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 && wq.size() == 2) begin
        check("ref_word0", wq[0], 64'h00000000_00000513);
        check("ref_word1", wq[1], 64'h00000004_00100593);
      end
      repeat (2) @(posedge clk); #1;
    end

    // Oversized length: error, no activity; next accepted start clears it
    wq.delete();
    start = 1'b1; len_words = 7'd65;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("len65_error", error, 1);
    check("len65_busy", busy, 0);
    check("len65_writes", wq.size(), 0);
    @(posedge clk); #1;
    rv = '{1, 0, -1, 1'b0, 1'b0, 1, 1};
    run_load(rv, "after_err");
    check("after_err_error", error, 0);

    // Zero length: immediate done, nothing else
    @(posedge clk); #1;
    wq.delete(); d0 = done_cnt; seen = 0; rdy_seen = 0;
    start = 1'b1; len_words = 7'd0;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done && seen == 0) seen = c;
      if (byte_ready) rdy_seen++;
      @(posedge clk); #1;
    end
    check("len0_done_cycle", seen, 1);
    check("len0_done_pulses", done_cnt - d0, 1);
    check("len0_writes", wq.size(), 0);
    check("len0_byte_ready", rdy_seen, 0);

    // rst mid-word: everything back to reset values, partial word dropped
    wq.delete();
    start = 1'b1; len_words = 7'd2;
    @(posedge clk); #1 start = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
    @(posedge clk); #1 byte_data = 8'hBB;
    @(posedge clk); #1 byte_data = 8'hCC; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_writes", wq.size(), 0);
    @(posedge clk); #1;

    // rst clears a sticky error
    start = 1'b1; len_words = 7'd100;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_clears_error", error, 0);
    @(posedge clk); #1;

    // Randomised loads against the word-level model
    for (int n = 0; n < 10; n++) begin
      rv.len  = $urandom_range(8, 1);
      rv.mode = $urandom_range(2, 0);
      rv.fixed = 1'b0;
      rv.poke  = ($urandom_range(1, 0) == 1);
      rv.abort_after = ($urandom_range(3, 0) == 0) ? $urandom_range(4 * rv.len - 1, 0) : -1;
      rv.exp_words = (rv.abort_after >= 0) ? rv.abort_after / 4 : rv.len;
      rv.exp_done  = (rv.abort_after >= 0) ? 0 : 1;
      run_load(rv, $sformatf("rand%0d", n));
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;
    end

    check("ready_held_in_recv", ready_drop, 0);
    check("wport_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
